// File: rtl/window_generator_pkg.sv
// Shared constants for the 3x3 window front end: pixel/window widths and FSM encoding.
package window_generator_pkg;

  localparam int PIXEL_W     = 8;
  localparam int KERNEL_SIZE = 3;
  localparam int WINDOW_W    = PIXEL_W * KERNEL_SIZE * KERNEL_SIZE;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/line_buffer.sv
// One image row of delay: reading an address returns the value written one row ago,
// i.e. the pre-write contents, while the same address is overwritten this cycle.
module line_buffer
  import window_generator_pkg::*;
#(
  parameter int DEPTH = 512,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [AW-1:0]      i_addr,
  input  logic [PIXEL_W-1:0] i_data,
  output logic [PIXEL_W-1:0] o_data
);

  logic [PIXEL_W-1:0] mem [DEPTH];

  assign o_data = mem[i_addr];

  // NOTE: the storage array has no reset so it maps onto RAM; stale rows are
  // never emitted because the FSM suppresses output until two rows are written.
  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_addr] <= i_data;
  end

endmodule

// File: rtl/window_generator.sv
// Turns a raster pixel stream into 3x3 windows (valid region only) using two
// row delay lines and a 3x3 shift register; one window per accepted pixel.
module window_generator
  import window_generator_pkg::*;
#(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic [PIXEL_W-1:0]  i_pixel_data,
  input  logic                i_pixel_valid,
  output logic [WINDOW_W-1:0] o_pixel_data,
  output logic                o_pixel_valid,
  output logic                o_frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0]       col;
  logic [RW-1:0]       row;
  state_t              state, state_next;
  logic                accept, last_col, last_row, emit, frame_last;
  logic [PIXEL_W-1:0]  lb0_q, lb1_q;
  logic [PIXEL_W-1:0]  new_col [KERNEL_SIZE];
  logic [WINDOW_W-1:0] win, win_next;

  assign accept   = i_pixel_valid;
  assign last_col = (col == COL_MAX);
  assign last_row = (row == ROW_MAX);

  // LB1 holds row r-1; its displaced value cascades into LB0 (row r-2).
  line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
    .i_clk  (i_clk),
    .i_we   (accept),
    .i_addr (col),
    .i_data (i_pixel_data),
    .o_data (lb1_q)
  );

  line_buffer #(.DEPTH(IMG_WIDTH)) u_lb0 (
    .i_clk  (i_clk),
    .i_we   (accept),
    .i_addr (col),
    .i_data (lb1_q),
    .o_data (lb0_q)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= FILL;
    else         state <= state_next;
  end

  // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      FILL: if (accept && row == RW'(1) && last_col) state_next = RUN;
      RUN:  if (accept && last_row && last_col)      state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  always_comb begin
    emit       = accept && (state == RUN) && (col >= CW'(2));
    frame_last = accept && last_row && last_col;
  end

  assign new_col[0] = lb0_q;
  assign new_col[1] = lb1_q;
  assign new_col[2] = i_pixel_data;

  always_comb begin
    win_next = win;
    for (int wr = 0; wr < KERNEL_SIZE; wr++) begin
      for (int wc = 0; wc < KERNEL_SIZE - 1; wc++) begin
        win_next[(wr*KERNEL_SIZE + wc)*PIXEL_W +: PIXEL_W] =
          win[(wr*KERNEL_SIZE + wc + 1)*PIXEL_W +: PIXEL_W];
      end
      win_next[(wr*KERNEL_SIZE + KERNEL_SIZE - 1)*PIXEL_W +: PIXEL_W] = new_col[wr];
    end
  end

  // The output register only loads on a valid window so it holds between windows.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      win           <= '0;
      o_pixel_data  <= '0;
      o_pixel_valid <= 1'b0;
      o_frame_done  <= 1'b0;
    end else begin
      if (accept) win <= win_next;
      if (emit)   o_pixel_data <= win_next;
      o_pixel_valid <= emit;
      o_frame_done  <= frame_last;
    end
  end

endmodule

// File: doc/window_generator.md
Name: window_generator

Overview:
- Front end of the 3x3 filter pipeline; sits directly upstream of the box-blur operations block.
- Accepts a raster-scan 8-bit pixel stream, buffers the two previous image rows and emits one 72-bit 3x3 window per accepted pixel.
- Emits a window only when a full 3x3 neighbourhood exists (valid region, no padding).
- Output pair o_pixel_data/o_pixel_valid feeds the filter's i_pixel_data/i_pixel_valid unchanged.

Parameters:
- IMG_WIDTH, 512, pixels per row (>=3)
- IMG_HEIGHT, 512, rows per frame (>=3)

Ports:
- i_clk  input  1  clock; all logic on rising edge
- i_rstn  input  1  asynchronous active-low reset
- i_pixel_data  input  8  incoming pixel, raster order (row-major, left to right)
- i_pixel_valid  input  1  pixel accepted on any cycle where high; no backpressure
- o_pixel_data  output  72  3x3 window; byte k = o_pixel_data[k*8+:8], k = wr*3+wc; wr 0 = oldest row, wc 0 = leftmost column
- o_pixel_valid  output  1  window valid, single-cycle per window
- o_frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Reset (async assert, sync release): o_pixel_data=0, o_pixel_valid=0, o_frame_done=0, col/row counters=0, FSM=FILL, window registers=0. Line-buffer contents are not cleared; stale data is never emitted.
- Counters:
  - col: 0..IMG_WIDTH-1; row: 0..IMG_HEIGHT-1.
  - Both advance only on accepted pixels; col wraps to 0 and increments row.
  - After (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0 and the next frame starts immediately.
- Line buffers: two IMG_WIDTH-deep 8-bit delay lines, LB1 (row r-1) and LB0 (row r-2). On an accepted pixel at column c:
  - read LB0[c], LB1[c];
  - write LB1[c]<=pixel and LB0[c]<=old LB1[c] in the same cycle;
  - read returns the pre-write value.
- Window shift: on each accepted pixel, the 3x3 register shifts one column left, and the new right column is {LB0[c], LB1[c], pixel} for wr 0,1,2.
- FSM:
  - FILL: rows 0-1, no output. Goes to RUN when the pixel (1, IMG_WIDTH-1) is accepted.
  - RUN: rows >= 2. Goes to FILL when the frame's last pixel is accepted.
- Output rule and latency:
  - If pixel (r,c) is accepted with r>=2 and c>=2, then in the next cycle o_pixel_valid=1 and the window holds rows r-2..r, cols c-2..c.
  - Otherwise o_pixel_valid=0 in the next cycle.
  - Latency is 1 cycle.
- o_pixel_data holds its last value while o_pixel_valid=0.
- Windows per frame = (IMG_WIDTH-2)*(IMG_HEIGHT-2). No window straddles a row boundary (c<2 is suppressed).
- Stalls: i_pixel_valid low freezes counters, FSM and window registers. Gaps of any length are allowed and do not change output content.
- o_frame_done is high in the cycle after the last pixel is accepted; it coincides with the final o_pixel_valid.
- Reset mid-frame: outputs drop to 0 asynchronously. After release, the next accepted pixel is (0,0) of a new frame.
- Arithmetic: counters are $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT) bits wide, with compare-to-max wrap (no overflow reliance).

Decomposition:
- Shared package (constants only): PIXEL_W=8, KERNEL_SIZE=3, WINDOW_W=PIXEL_W*KERNEL_SIZE*KERNEL_SIZE=72, FSM state encoding FILL/RUN.
- One sub-module: line_buffer (parameter DEPTH; ports i_clk, i_we, i_addr, i_data, o_data; combinational read of the pre-write value). Instantiated twice.
- Counters, FSM and window registers stay in window_generator.

Test Plan (IMG_WIDTH=5, IMG_HEIGHT=4, pixel value = r*16+c unless stated):
- Continuous stream of 20 pixels -> exactly 6 windows. The first window follows input (2,2): bytes k0..k8 = 00,01,02,10,11,12,20,21,22, i.e. o_pixel_data=72'h222120121110020100. The last window follows (3,4): bytes 12,13,14,22,23,24,32,33,34.
- Same frame with pseudo-random i_pixel_valid gaps (1-5 cycles) -> identical 6 windows in order. o_pixel_valid is high only in the cycle after an accepted pixel with r>=2, c>=2.
- Two back-to-back frames, frame 2 value = 0x80+r*16+c -> frame 2's first window is 80,81,82,90,91,92,A0,A1,A2 (no frame-1 data). o_frame_done pulses exactly twice, each coincident with the final window.
- Assert i_rstn=0 after accepting (2,3) -> o_pixel_valid, o_frame_done and o_pixel_data go to 0 immediately. After release, a full new frame yields exactly 6 windows, the first equal to 72'h222120121110020100.
- Chain with the box-blur filter, constant image 90 (IMG_WIDTH=8, IMG_HEIGHT=6) -> 24 filter results, all 90. Ramp image value=c -> each result equals the window's centre column value.
